// File: rtl/mem_sweep_sched_pkg.sv
// Shared types and default sizes for the mem_sweep_sched controller.
package mem_sched_pkg;

    localparam int DEF_DEPTH = 8;
    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT_SWEEP,
        ST_INCR_SWEEP
    } sched_state_t;

endpackage

// File: rtl/mem_sweep_sched_if.sv
// Sweep control, two write requesters and the read port of mem_sweep_sched.
interface mem_sweep_sched_if
    import mem_sched_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = $clog2(DEPTH)
) ();

    logic             init_req;
    logic             incr_req;
    logic             busy;
    logic             sweep_done;
    logic             a_req;
    logic [AW-1:0]    a_addr;
    logic [WIDTH-1:0] a_data;
    logic             a_gnt;
    logic             b_req;
    logic [AW-1:0]    b_addr;
    logic [WIDTH-1:0] b_data;
    logic             b_gnt;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;

    modport master (
        output init_req, incr_req, a_req, a_addr, a_data,
               b_req, b_addr, b_data, rd_addr,
        input  busy, sweep_done, a_gnt, b_gnt, rd_data
    );

    modport slave (
        input  init_req, incr_req, a_req, a_addr, a_data,
               b_req, b_addr, b_data, rd_addr,
        output busy, sweep_done, a_gnt, b_gnt, rd_data
    );

endinterface

// File: rtl/mem_sweep_sched_rr_arb2.sv
// Two-way round-robin arbiter; index 0 is requester A, index 1 is requester B.
module rr_arb2 (
    input  logic       i_en,
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic [1:0] o_gnt,
    output logic       o_ptr_nxt
);

    logic [1:0] w_gnt;

    // i_ptr=0 favours A, i_ptr=1 favours B; a lone requester always wins
    assign w_gnt[0] = i_en & i_req[0] & (~i_req[1] | ~i_ptr);
    assign w_gnt[1] = i_en & i_req[1] & (~i_req[0] |  i_ptr);

    assign o_gnt = w_gnt;

    always_comb begin
        o_ptr_nxt = i_ptr;
        if (w_gnt[0]) begin
            o_ptr_nxt = 1'b1;
        end else if (w_gnt[1]) begin
            o_ptr_nxt = 1'b0;
        end
    end

endmodule

// File: rtl/mem_sweep_sched.sv
// Flop-array memory with round-robin client writes and init/increment sweeps.
// Define MEM_SCHED_BULK_SWEEP_EN to update every entry in a single sweep cycle.
module mem_sweep_sched
    import mem_sched_pkg::*;
#(
    parameter  int DEPTH = DEF_DEPTH,
    parameter  int WIDTH = DEF_WIDTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    mem_sweep_sched_if.slave   bus
);

    sched_state_t     r_state;
    sched_state_t     w_state_nxt;
    logic             r_busy;
    logic             r_done;
    logic             r_ptr;
    logic             w_ptr_nxt;
    logic [1:0]       w_gnt;
    logic             w_start;
    logic             w_arb_en;
    logic             w_sweep_end;
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Requests arriving in the sweep_done cycle are dropped, but grants still flow
    assign w_start  = (r_state == ST_IDLE) && !r_done && (bus.init_req || bus.incr_req);
    assign w_arb_en = (r_state == ST_IDLE) && !w_start;

`ifdef MEM_SCHED_BULK_SWEEP_EN
    assign w_sweep_end = 1'b1;
`else
    logic [AW-1:0] r_idx;

    assign w_sweep_end = (r_idx == AW'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_idx <= '0;
        end else if (r_state != ST_IDLE) begin
            r_idx <= w_sweep_end ? '0 : r_idx + 1'b1;
        end
    end
`endif

    rr_arb2 u_arb (
        .i_en      (w_arb_en),
        .i_req     ({bus.b_req, bus.a_req}),
        .i_ptr     (r_ptr),
        .o_gnt     (w_gnt),
        .o_ptr_nxt (w_ptr_nxt)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = bus.init_req ? ST_INIT_SWEEP : ST_INCR_SWEEP;
                end
            end
            ST_INIT_SWEEP, ST_INCR_SWEEP: begin
                if (w_sweep_end) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ptr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= (r_state != ST_IDLE) && (w_state_nxt == ST_IDLE);
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
`ifdef MEM_SCHED_BULK_SWEEP_EN
                ST_INIT_SWEEP: begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_mem[i] <= WIDTH'(i);
                    end
                end
                ST_INCR_SWEEP: begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_mem[i] <= r_mem[i] + 1'b1;
                    end
                end
`else
                ST_INIT_SWEEP: r_mem[r_idx] <= WIDTH'(r_idx);
                ST_INCR_SWEEP: r_mem[r_idx] <= r_mem[r_idx] + 1'b1;
`endif
                default: begin
                    if (w_gnt[0]) begin
                        r_mem[bus.a_addr] <= bus.a_data;
                    end else if (w_gnt[1]) begin
                        r_mem[bus.b_addr] <= bus.b_data;
                    end
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.sweep_done = r_done;
    assign bus.a_gnt      = w_gnt[0];
    assign bus.b_gnt      = w_gnt[1];
    assign bus.rd_data    = r_mem[bus.rd_addr];

endmodule

// File: tb/tb_mem_sweep_sched.sv
// Bench for mem_sweep_sched: directed scenarios plus random traffic against a memory model.
module tb_mem_sweep_sched;

    localparam int DEPTH = 8;
    localparam int WIDTH = 4;
    localparam int AW    = 3;
`ifdef MEM_SCHED_BULK_SWEEP_EN
    localparam int BUSY_LEN = 1;
`else
    localparam int BUSY_LEN = DEPTH;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_sweep_sched_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    mem_sweep_sched #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // model: sweep kind 0=none 1=init 2=incr, entries written so far, done flag, RR pointer
    int               m_kind  = 0;
    int               m_pos   = 0;
    bit               m_done  = 0;
    bit               m_ptr   = 0;
    bit               m_valid = 0;
    bit               m_ga    = 0;
    bit               m_gb    = 0;
    logic [WIDTH-1:0] m_mem [DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void exp_gnt(output bit ga, output bit gb);
        bit start;
        bit en;
        start = (m_kind == 0) && !m_done && (bus.init_req || bus.incr_req);
        en    = (m_kind == 0) && !start;
        ga    = en && bus.a_req && (!bus.b_req || !m_ptr);
        gb    = en && bus.b_req && (!bus.a_req ||  m_ptr);
    endfunction

    function automatic void apply_sweep(input int idx);
        if (m_kind == 1) m_mem[idx] = WIDTH'(idx);
        else             m_mem[idx] = m_mem[idx] + 1'b1;
    endfunction

    initial begin : model
        bit ga;
        bit gb;
        bit nd;
        forever begin
            @(posedge clk);
            exp_gnt(ga, gb);
            if (!reset) begin
                m_valid = 1;
                m_kind  = 0;
                m_pos   = 0;
                m_done  = 0;
                m_ptr   = 0;
                m_ga    = 0;
                m_gb    = 0;
                for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            end else begin
                nd   = 0;
                m_ga = ga;
                m_gb = gb;
                if (m_kind == 0) begin
                    if (!m_done && (bus.init_req || bus.incr_req)) begin
                        m_kind = bus.init_req ? 1 : 2;
                        m_pos  = 0;
                    end else if (ga) begin
                        m_mem[bus.a_addr] = bus.a_data;
                        m_ptr = 1;
                    end else if (gb) begin
                        m_mem[bus.b_addr] = bus.b_data;
                        m_ptr = 0;
                    end
                end else begin
`ifdef MEM_SCHED_BULK_SWEEP_EN
                    for (int i = 0; i < DEPTH; i++) apply_sweep(i);
                    m_pos = DEPTH;
`else
                    apply_sweep(m_pos);
                    m_pos++;
`endif
                    if (m_pos == DEPTH) begin
                        m_kind = 0;
                        m_pos  = 0;
                        nd     = 1;
                    end
                end
                m_done = nd;
            end
        end
    end

    initial begin : compare
        bit ga;
        bit gb;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                exp_gnt(ga, gb);
                chk("busy",       bus.busy,       32'(m_kind != 0));
                chk("sweep_done", bus.sweep_done, 32'(m_done));
                chk("a_gnt",      bus.a_gnt,      32'(ga));
                chk("b_gnt",      bus.b_gnt,      32'(gb));
                chk("rd_data",    bus.rd_data,    32'(m_mem[bus.rd_addr]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string name, input int addr, input int exp);
        bus.rd_addr = AW'(addr);
        #1;
        chk(name, bus.rd_data, 32'(exp));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic run_sweep(input bit do_init, input bit do_incr);
        int n;
        bus.init_req = do_init;
        bus.incr_req = do_incr;
        tick();
        bus.init_req = 1'b0;
        bus.incr_req = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        chk("busy_len", n, BUSY_LEN);
        chk("done_pulse", bus.sweep_done, 1);
        tick();
    endtask

    initial begin : driver
        int n;
        reset = 1'b0;
        bus.init_req = 0; bus.incr_req = 0;
        bus.a_req = 0; bus.a_addr = '0; bus.a_data = '0;
        bus.b_req = 0; bus.b_addr = '0; bus.b_data = '0;
        bus.rd_addr = '0;
        tick(); tick(); tick();
        reset = 1'b1;

        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.sweep_done, 0);
        rd_chk("rst_mem3", 3, 0);

        run_sweep(1, 0);
        for (int i = 0; i < DEPTH; i++) rd_chk("init_val", i, i);

        repeat (8) run_sweep(0, 1);
        rd_chk("incr8_addr7", 7, 15);
        run_sweep(0, 1);
        rd_chk("incr9_addr7", 7, 0);
        rd_chk("incr9_addr0", 0, 9);
        repeat (7) run_sweep(0, 1);
        for (int i = 0; i < DEPTH; i++) rd_chk("incr16_val", i, i);

        // arbitration: both requesting, expect A, B, A, B
        do_reset();
        bus.a_req = 1; bus.a_addr = 2; bus.a_data = 4'h5;
        bus.b_req = 1; bus.b_addr = 3; bus.b_data = 4'hA;
        #1; chk("arb0_a", bus.a_gnt, 1); chk("arb0_b", bus.b_gnt, 0);
        tick(); rd_chk("arb0_rd", 2, 5);
        bus.a_addr = 4; bus.a_data = 4'h6;
        #1; chk("arb1_a", bus.a_gnt, 0); chk("arb1_b", bus.b_gnt, 1);
        tick(); rd_chk("arb1_rd", 3, 4'hA);
        bus.b_addr = 5; bus.b_data = 4'hC;
        #1; chk("arb2_a", bus.a_gnt, 1); chk("arb2_b", bus.b_gnt, 0);
        tick(); rd_chk("arb2_rd", 4, 6);
        bus.a_addr = 6; bus.a_data = 4'h7;
        #1; chk("arb3_a", bus.a_gnt, 0); chk("arb3_b", bus.b_gnt, 1);
        tick(); rd_chk("arb3_rd", 5, 4'hC);
        bus.a_req = 0; bus.b_req = 0;
        tick();

        // client stalled by a sweep, granted in the sweep_done cycle
        bus.incr_req = 1;
        tick();
        bus.incr_req = 0;
        bus.a_req = 1; bus.a_addr = 1; bus.a_data = 4'hD;
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            #1; chk("stall_a_gnt", bus.a_gnt, 0);
            n++;
            tick();
        end
        chk("stall_busy_len", n, BUSY_LEN);
        chk("stall_done", bus.sweep_done, 1);
        chk("stall_grant_in_done", bus.a_gnt, 1);
        tick();
        bus.a_req = 0;
        rd_chk("stall_write", 1, 4'hD);
        tick();

        // simultaneous start: init wins; incr during busy and in done cycle dropped
        bus.init_req = 1; bus.incr_req = 1;
        tick();
        bus.init_req = 0; bus.incr_req = 0;
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            bus.incr_req = (n == 0);
            n++;
            tick();
        end
        chk("simul_busy_len", n, BUSY_LEN);
        chk("simul_done", bus.sweep_done, 1);
        bus.incr_req = 1;
        tick();
        bus.incr_req = 0;
        chk("drop_in_done", bus.busy, 0);
        tick();
        chk("drop_in_done2", bus.busy, 0);
        for (int i = 0; i < DEPTH; i++) rd_chk("simul_init_val", i, i);

        // reset in the middle of a sweep
        bus.incr_req = 1;
        tick();
        bus.incr_req = 0;
        repeat ((BUSY_LEN >= 4) ? 3 : BUSY_LEN - 1) tick();
        chk("mid_busy", bus.busy, 1);
        reset = 0;
        tick();
        reset = 1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.sweep_done, 0);
        for (int i = 0; i < DEPTH; i++) rd_chk("abort_mem", i, 0);
        tick();
        chk("abort_no_done", bus.sweep_done, 0);

        // random traffic; ungranted requesters hold their request
        for (int c = 0; c < 3000; c++) begin
            if (!(bus.a_req && !m_ga)) begin
                bus.a_req  = ($urandom_range(0, 2) != 0);
                bus.a_addr = AW'($urandom_range(0, DEPTH - 1));
                bus.a_data = WIDTH'($urandom_range(0, 15));
            end
            if (!(bus.b_req && !m_gb)) begin
                bus.b_req  = ($urandom_range(0, 2) != 0);
                bus.b_addr = AW'($urandom_range(0, DEPTH - 1));
                bus.b_data = WIDTH'($urandom_range(0, 15));
            end
            bus.init_req = ($urandom_range(0, 39) == 0);
            bus.incr_req = ($urandom_range(0, 29) == 0);
            bus.rd_addr  = AW'($urandom_range(0, DEPTH - 1));
            reset        = ($urandom_range(0, 499) != 0);
            tick();
        end

        reset = 1;
        bus.init_req = 0; bus.incr_req = 0;
        bus.a_req = 0; bus.b_req = 0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
